// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_pkg : shared sizes and entry type for the register-file writeback queue |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package wb_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;

  typedef struct packed {
    logic [WB_AW-1:0] rd;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_fifo : circular buffer, up to two pushes and one pop per cycle,         |
// |           with every slot and its valid bit exposed for hazard scanning     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push_a,
  input  wb_entry_t                   entry_a,
  input  logic                        push_b,
  input  wb_entry_t                   entry_b,
  input  logic                        pop,
  output wb_entry_t                   head,
  output wb_entry_t [DEPTH-1:0]       entries,
  output logic      [DEPTH-1:0]       valid,
  output logic      [PW-1:0]          head_ptr,
  output logic      [CW-1:0]          count
);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic      [DEPTH-1:0] r_valid;
  logic      [PW-1:0]    r_wr_ptr;
  logic      [PW-1:0]    r_rd_ptr;
  logic      [CW-1:0]    r_count;
  logic      [PW-1:0]    w_wr_ptr1;
  logic      [CW-1:0]    w_n_push;

  // push_b is only ever asserted together with push_a, so it lands one slot later
  assign w_wr_ptr1 = r_wr_ptr + 1'b1;
  assign w_n_push  = CW'(push_a) + CW'(push_b);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      if (push_a) r_valid[r_wr_ptr]  <= 1'b1;
      if (push_b) r_valid[w_wr_ptr1] <= 1'b1;
      r_wr_ptr <= r_wr_ptr + w_n_push[PW-1:0];
      r_count  <= r_count + w_n_push - CW'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mem <= '0;
    end else begin
      if (push_a) r_mem[r_wr_ptr]  <= entry_a;
      if (push_b) r_mem[w_wr_ptr1] <= entry_b;
    end
  end

  assign head     = r_mem[r_rd_ptr];
  assign entries  = r_mem;
  assign valid    = r_valid;
  assign head_ptr = r_rd_ptr;
  assign count    = r_count;

endmodule : wb_fifo
`default_nettype wire

// File: rtl/regfile_wb_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_wb_queue : in-order writeback queue feeding the register file,     |
// |                    with RS1/RS2 pending-write detection and forwarding      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module regfile_wb_queue
  import wb_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  parameter  int DW    = WB_DW,
  parameter  int AW    = WB_AW,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          hold,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          rs1_pend,
  output logic          rs2_pend,
  output logic [DW-1:0] rs1_fwd,
  output logic [DW-1:0] rs2_fwd,
  output logic          wb_w,
  output logic [AW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic [CW-1:0] count
);

  wb_entry_t             w_head;
  wb_entry_t [DEPTH-1:0] w_entries;
  logic      [DEPTH-1:0] w_valid;
  logic      [PW-1:0]    w_head_ptr;
  logic      [CW-1:0]    w_free;
  logic                  w_mem_acc;
  logic                  w_alu_acc;
  logic                  w_push_a;
  logic                  w_push_b;
  logic                  w_pop;
  wb_entry_t             w_mem_entry;
  wb_entry_t             w_alu_entry;

  // Free space is judged on current occupancy only; a same-cycle pop gives no credit
  assign w_free    = CW'(DEPTH) - count;
  assign mem_ready = reset & (w_free >= CW'(1));
  assign alu_ready = reset & ((w_free >= CW'(2)) | ((w_free == CW'(1)) & ~mem_valid));

  assign w_mem_acc   = mem_valid & mem_ready;
  assign w_alu_acc   = alu_valid & alu_ready;
  assign w_mem_entry = '{rd: mem_rd, data: mem_data};
  assign w_alu_entry = '{rd: alu_rd, data: alu_data};

  // The load result always takes the first slot so it drains ahead of the ALU result
  assign w_push_a = w_mem_acc | w_alu_acc;
  assign w_push_b = w_mem_acc & w_alu_acc;
  assign w_pop    = (count != '0) & ~hold;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_a   (w_push_a),
    .entry_a  (w_mem_acc ? w_mem_entry : w_alu_entry),
    .push_b   (w_push_b),
    .entry_b  (w_alu_entry),
    .pop      (w_pop),
    .head     (w_head),
    .entries  (w_entries),
    .valid    (w_valid),
    .head_ptr (w_head_ptr),
    .count    (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_w    <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (w_pop) begin
      wb_w    <= (w_head.rd != '0);
      wb_rd   <= w_head.rd;
      wb_data <= w_head.data;
    end else begin
      wb_w    <= 1'b0;
    end
  end

  logic [AW-1:0] w_rs   [2];
  logic          w_pend [2];
  logic [DW-1:0] w_fwd  [2];

  assign w_rs[0] = rs1;
  assign w_rs[1] = rs2;

  // Scan from the output register through oldest-to-youngest so the youngest match wins
  always_comb begin
    logic [PW-1:0] slot;
    slot = '0;
    for (int p = 0; p < 2; p++) begin
      w_pend[p] = 1'b0;
      w_fwd[p]  = '0;
      if (w_rs[p] != '0) begin
        if (wb_w && (wb_rd == w_rs[p])) begin
          w_pend[p] = 1'b1;
          w_fwd[p]  = wb_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
          slot = w_head_ptr + PW'(k);
          if (w_valid[slot] && (w_entries[slot].rd == w_rs[p])) begin
            w_pend[p] = 1'b1;
            w_fwd[p]  = w_entries[slot].data;
          end
        end
      end
    end
  end

  assign rs1_pend = w_pend[0];
  assign rs2_pend = w_pend[1];
  assign rs1_fwd  = w_fwd[0];
  assign rs2_fwd  = w_fwd[1];

endmodule : regfile_wb_queue
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_wb_queue : scoreboard bench for the writeback queue             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_regfile_wb_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid, alu_valid, hold;
  logic [4:0]  mem_rd, alu_rd, rs1, rs2;
  logic [31:0] mem_data, alu_data;
  logic        mem_ready, alu_ready, rs1_pend, rs2_pend, wb_w;
  logic [31:0] rs1_fwd, rs2_fwd, wb_data;
  logic [4:0]  wb_rd;
  logic [2:0]  count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  regfile_wb_queue dut (
    .clock     (clock),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .hold      (hold),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_pend  (rs1_pend),
    .rs2_pend  (rs2_pend),
    .rs1_fwd   (rs1_fwd),
    .rs2_fwd   (rs2_fwd),
    .wb_w      (wb_w),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .count     (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_mem(input logic v, input logic [4:0] rd, input logic [31:0] data);
    mem_valid = v;
    mem_rd    = rd;
    mem_data  = data;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] data);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = data;
  endtask

  // Every register-file write is matched against the next expected write in order
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset === 1'b1 && wb_w === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%08h, required no write", wb_rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        check("wb_data", wb_data, e.data);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    hold = 1'b0;
    rs1  = 5'd0;
    rs2  = 5'd0;
    drive_mem(1'b1, 5'd1, 32'h1111_1111);
    drive_alu(1'b1, 5'd2, 32'h2222_2222);

    // reset held low with valids asserted
    repeat (3) @(posedge clock);
    #2;
    check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("rst_wb_w", {31'd0, wb_w}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    drive_mem(1'b0, 5'd0, 32'd0);
    drive_alu(1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    #2;
    check("rel_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("rel_alu_ready", {31'd0, alu_ready}, 32'd1);

    // single ALU write
    drive_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
    expect_wr(5'd5, 32'hDEAD_BEEF);
    #1;
    check("single_alu_ready", {31'd0, alu_ready}, 32'd1);
    cycle();
    drive_alu(1'b0, 5'd0, 32'd0);
    check("single_count1", {29'd0, count}, 32'd1);
    cycle();
    check("single_wb_w", {31'd0, wb_w}, 32'd1);
    check("single_count0", {29'd0, count}, 32'd0);
    cycle();
    check("single_wb_w_drop", {31'd0, wb_w}, 32'd0);

    // dual push, load ahead of ALU
    drive_mem(1'b1, 5'd3, 32'h11);
    drive_alu(1'b1, 5'd4, 32'h22);
    expect_wr(5'd3, 32'h11);
    expect_wr(5'd4, 32'h22);
    #1;
    check("dual_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("dual_alu_ready", {31'd0, alu_ready}, 32'd1);
    cycle();
    drive_mem(1'b0, 5'd0, 32'd0);
    drive_alu(1'b0, 5'd0, 32'd0);
    check("dual_count2", {29'd0, count}, 32'd2);
    cycle();
    check("dual_count1", {29'd0, count}, 32'd1);
    cycle();
    check("dual_count0", {29'd0, count}, 32'd0);
    cycle();

    // fill under hold, then drain one per cycle
    hold = 1'b1;
    drive_mem(1'b1, 5'd1, 32'h101);
    drive_alu(1'b1, 5'd2, 32'h102);
    expect_wr(5'd1, 32'h101);
    expect_wr(5'd2, 32'h102);
    cycle();
    check("fill_count2", {29'd0, count}, 32'd2);
    drive_mem(1'b1, 5'd6, 32'h106);
    drive_alu(1'b1, 5'd8, 32'h108);
    expect_wr(5'd6, 32'h106);
    expect_wr(5'd8, 32'h108);
    #1;
    check("fill_free2_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("fill_free2_alu_ready", {31'd0, alu_ready}, 32'd1);
    cycle();
    drive_mem(1'b1, 5'd9, 32'h901);
    drive_alu(1'b1, 5'd9, 32'h902);
    check("full_count4", {29'd0, count}, 32'd4);
    check("full_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("full_alu_ready", {31'd0, alu_ready}, 32'd0);
    cycle();
    check("full_ignored_count", {29'd0, count}, 32'd4);
    drive_mem(1'b0, 5'd0, 32'd0);
    drive_alu(1'b0, 5'd0, 32'd0);
    hold = 1'b0;
    #1;
    check("full_no_pop_credit", {31'd0, mem_ready}, 32'd0);
    cycle();
    check("drain_count3", {29'd0, count}, 32'd3);
    check("drain_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("drain_alu_ready_free1", {31'd0, alu_ready}, 32'd1);
    drive_mem(1'b1, 5'd13, 32'h113);
    expect_wr(5'd13, 32'h113);
    #1;
    check("free1_alu_blocked", {31'd0, alu_ready}, 32'd0);
    check("free1_mem_ready", {31'd0, mem_ready}, 32'd1);
    cycle();
    drive_mem(1'b0, 5'd0, 32'd0);
    check("pushpop_count3", {29'd0, count}, 32'd3);
    cycle();
    check("drain_count2", {29'd0, count}, 32'd2);
    cycle();
    check("drain_count1", {29'd0, count}, 32'd1);
    cycle();
    check("drain_count0", {29'd0, count}, 32'd0);

    // hazard detection and youngest-first forwarding
    hold = 1'b1;
    rs1  = 5'd7;
    rs2  = 5'd0;
    drive_mem(1'b1, 5'd7, 32'hA);
    drive_alu(1'b1, 5'd7, 32'hB);
    expect_wr(5'd7, 32'hA);
    expect_wr(5'd7, 32'hB);
    #1;
    check("hz_not_yet_visible", {31'd0, rs1_pend}, 32'd0);
    cycle();
    drive_mem(1'b0, 5'd0, 32'd0);
    drive_alu(1'b1, 5'd0, 32'hC);
    check("hz_rs1_pend", {31'd0, rs1_pend}, 32'd1);
    check("hz_rs1_fwd_young", rs1_fwd, 32'hB);
    check("hz_rs2_pend_r0", {31'd0, rs2_pend}, 32'd0);
    check("hz_rs2_fwd_r0", rs2_fwd, 32'd0);
    cycle();
    drive_alu(1'b0, 5'd0, 32'd0);
    check("hz_count3", {29'd0, count}, 32'd3);
    check("hz_rs2_r0_entry", {31'd0, rs2_pend}, 32'd0);
    hold = 1'b0;
    cycle();
    check("hz_pop1_wb_w", {31'd0, wb_w}, 32'd1);
    check("hz_pop1_fwd_queue", rs1_fwd, 32'hB);
    cycle();
    check("hz_pop2_pend_outreg", {31'd0, rs1_pend}, 32'd1);
    check("hz_pop2_fwd_outreg", rs1_fwd, 32'hB);
    cycle();
    check("hz_r0_wb_w", {31'd0, wb_w}, 32'd0);
    check("hz_r0_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("hz_r0_wb_data", wb_data, 32'hC);
    check("hz_empty_pend", {31'd0, rs1_pend}, 32'd0);
    check("hz_empty_fwd", rs1_fwd, 32'd0);
    check("hz_count0", {29'd0, count}, 32'd0);

    // asynchronous reset with pending entries
    rs1  = 5'd0;
    hold = 1'b1;
    drive_mem(1'b1, 5'd10, 32'h10A);
    drive_alu(1'b1, 5'd11, 32'h10B);
    cycle();
    drive_mem(1'b0, 5'd0, 32'd0);
    drive_alu(1'b1, 5'd12, 32'h10C);
    cycle();
    drive_alu(1'b0, 5'd0, 32'd0);
    check("ar_count3", {29'd0, count}, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("ar_count0", {29'd0, count}, 32'd0);
    check("ar_wb_w", {31'd0, wb_w}, 32'd0);
    check("ar_mem_ready", {31'd0, mem_ready}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    hold  = 1'b0;
    repeat (6) cycle();
    check("ar_count_after", {29'd0, count}, 32'd0);
    check("ar_wb_w_after", {31'd0, wb_w}, 32'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_wb_queue
`default_nettype wire
